// File: rtl/clk_wait_timer.sv
// Multi-channel "wait N clocks" timer: independent one-shot/periodic down-counters
// with abort and restart, plus a free-running cycle counter.
module clk_wait_timer #(
  parameter int NumChannels = 4,
  parameter int CntWidth    = 16,
  parameter int CycWidth    = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumChannels-1:0]          start_i,
  input  logic [NumChannels-1:0]          stop_i,
  input  logic [NumChannels-1:0]          periodic_i,
  input  logic [NumChannels*CntWidth-1:0] num_clks_i,
  output logic [NumChannels-1:0]          busy_o,
  output logic [NumChannels-1:0]          done_o,
  output logic [NumChannels*CntWidth-1:0] remaining_o,
  output logic [CycWidth-1:0]             cycle_cnt_o
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

  logic [CycWidth-1:0] cyc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cyc_q <= '0;
    else       cyc_q <= cyc_q + {{(CycWidth-1){1'b0}}, 1'b1};
  end

  assign cycle_cnt_o = cyc_q;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] reload_q, reload_d;
    logic [CntWidth-1:0] n_req;
    logic                per_q, per_d;
    logic                done_q, done_d;

    assign n_req = num_clks_i[c*CntWidth +: CntWidth];

    // Abort beats restart beats counting; a zero-length wait completes immediately.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      per_d    = per_q;
      done_d   = 1'b0;
      if (stop_i[c]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (start_i[c]) begin
        if (n_req != '0) begin
          state_d  = COUNT;
          cnt_d    = n_req;
          reload_d = n_req;
          per_d    = periodic_i[c];
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end else if (state_q == COUNT) begin
        if (cnt_q > CntWidth'(1)) begin
          cnt_d = cnt_q - CntWidth'(1);
        end else begin
          done_d = 1'b1;
          if (per_q) begin
            cnt_d = reload_q;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        reload_q <= '0;
        per_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        reload_q <= reload_d;
        per_q    <= per_d;
        done_q   <= done_d;
      end
    end

    assign busy_o[c]                            = (state_q == COUNT);
    assign done_o[c]                            = done_q;
    assign remaining_o[c*CntWidth +: CntWidth]  = cnt_q;
  end

endmodule
